pll_lock_sequencer: RTL and testbench

Sequences the system PLL from power-up to a clean, lock-qualified core reset. It holds the PLL in reset, waits for `locked` with a timeout and retries, and requires lock to be stable before it releases the downstream core reset. It re-runs the sequence on lock loss or on a software restart. It sits beside the PLL wrapper, runs on the free-running 50 MHz reference clock, and drives the PLL `rst` input and the core reset tree.

---
 rtl/pll_lock_sequencer.sv | 129 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL power-up sequencer: holds the PLL in reset, qualifies lock with timeout and
// retry, and releases the core reset only once lock has been stable.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4,
  parameter int CNT_W         = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       core_reset,
  output logic       ready,
  output logic       lock_fail,
  output logic [7:0] relock_count
);

  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRY);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             sync_p0;
  logic             sync_p1;
  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       timeout_cnt;
  logic [7:0]       timeout_inc;
  logic             timeout_hit;
  logic             lock_lost;
  logic             run_entry;
  logic             entering;

  always_comb begin
    nxt_state   = state;
    timeout_hit = 1'b0;
    lock_lost   = 1'b0;
    run_entry   = 1'b0;
    if (restart) begin
      nxt_state = RESET_PLL;
    end else begin
      case (state)
        RESET_PLL: if (cnt == RST_LAST) nxt_state = WAIT_LOCK;
        WAIT_LOCK: begin
          if (sync_p1) begin
            nxt_state = STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            nxt_state   = RESET_PLL;
            timeout_hit = 1'b1;
          end
        end
        STABLE: begin
          // Any dropout restarts qualification without resetting the PLL.
          if (!sync_p1) begin
            nxt_state = WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            nxt_state = RUN;
            run_entry = 1'b1;
          end
        end
        RUN: begin
          if (!sync_p1) begin
            nxt_state = RESET_PLL;
            lock_lost = 1'b1;
          end
        end
        default: nxt_state = RESET_PLL;
      endcase
    end
  end

  // Restart re-enters RESET_PLL even from RESET_PLL, so it always restarts the dwell.
  assign entering    = restart || (nxt_state != state);
  assign timeout_inc = sat_inc8(timeout_cnt);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0      <= 1'b0;
      sync_p1      <= 1'b0;
      state        <= RESET_PLL;
      cnt          <= '0;
      timeout_cnt  <= '0;
      pll_rst      <= 1'b1;
      core_reset   <= 1'b1;
      ready        <= 1'b0;
      lock_fail    <= 1'b0;
      relock_count <= '0;
    end else begin
      // Stage p0/p1: two-flop synchronizer for the asynchronous lock input.
      sync_p0 <= locked;
      sync_p1 <= sync_p0;

      state <= nxt_state;
      if (entering) begin
        cnt <= '0;
      end else if (state != RUN) begin
        cnt <= cnt + CNT_ONE;
      end

      pll_rst    <= (nxt_state == RESET_PLL);
      core_reset <= (nxt_state != RUN);
      ready      <= (nxt_state == RUN);

      if (restart) begin
        timeout_cnt <= '0;
        lock_fail   <= 1'b0;
      end else if (timeout_hit) begin
        timeout_cnt <= timeout_inc;
        if (timeout_inc >= RETRY_LIMIT) lock_fail <= 1'b1;
      end else if (run_entry) begin
        timeout_cnt <= '0;
      end

      if (lock_lost) relock_count <= sat_inc8(relock_count);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios with literal expectations plus
// randomized lock/restart stimulus checked every cycle against a duration-based model.
module tb_pll_lock_sequencer;

  localparam int RSTC = 4;
  localparam int TO   = 20;
  localparam int ST   = 8;
  localparam int MR   = 3;
  localparam int CW   = 20;

  logic       refclk  = 1'b0;
  logic       rst_n   = 1'b1;
  logic       locked  = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst;
  logic       core_reset;
  logic       ready;
  logic       lock_fail;
  logic [7:0] relock_count;

  pll_lock_sequencer #(
    .RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(ST),
    .MAX_RETRY(MR), .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .locked(locked), .restart(restart),
    .pll_rst(pll_rst), .core_reset(core_reset), .ready(ready),
    .lock_fail(lock_fail), .relock_count(relock_count)
  );

  always #5 refclk = ~refclk;

  int n_cmp = 0;
  int n_bad = 0;
  int ecnt  = 0;
  bit chk_en = 1'b0;

  initial forever begin
    @(posedge refclk);
    ecnt++;
  end

  // Reference model: phase plus time-in-phase, with the lock input seen two edges late.
  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;

  int m_phase = P_RST;
  int m_since = 0;
  int m_timeouts = 0;
  int m_relock = 0;
  int m_nxt;
  bit m_fail = 1'b0;
  bit h0 = 1'b0;
  bit h1 = 1'b0;
  bit m_ls;

  initial forever begin
    @(posedge refclk or negedge rst_n);
    if (!rst_n) begin
      m_phase = P_RST; m_since = 0; m_timeouts = 0; m_relock = 0;
      m_fail = 1'b0; h0 = 1'b0; h1 = 1'b0;
    end else begin
      m_ls = h1;
      m_since++;
      m_nxt = m_phase;
      if (restart) begin
        m_nxt = P_RST; m_timeouts = 0; m_fail = 1'b0;
      end else if (m_phase == P_RST) begin
        if (m_since == RSTC) m_nxt = P_WAIT;
      end else if (m_phase == P_WAIT) begin
        if (m_ls) m_nxt = P_STAB;
        else if (m_since == TO) begin
          m_nxt = P_RST;
          if (m_timeouts < 255) m_timeouts++;
          if (m_timeouts >= MR) m_fail = 1'b1;
        end
      end else if (m_phase == P_STAB) begin
        if (!m_ls) m_nxt = P_WAIT;
        else if (m_since == ST) begin m_nxt = P_RUN; m_timeouts = 0; end
      end else begin
        if (!m_ls) begin m_nxt = P_RST; if (m_relock < 255) m_relock++; end
      end
      if (restart || m_nxt != m_phase) m_since = 0;
      m_phase = m_nxt;
      h1 = h0;
      h0 = locked;
    end
  end

  logic [11:0] act_v, exp_v;
  initial forever begin
    @(negedge refclk);
    if (chk_en) begin
      act_v = {pll_rst, core_reset, ready, lock_fail, relock_count};
      exp_v = {(m_phase == P_RST), (m_phase != P_RUN), (m_phase == P_RUN), m_fail, 8'(m_relock)};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL cycle_model @%0d: got pll_rst=%b core_reset=%b ready=%b lock_fail=%b relock=%0d, required %b %b %b %b %0d",
                 ecnt, act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                 exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic bit sig(input int which);
    case (which)
      0:       return pll_rst;
      1:       return core_reset;
      2:       return ready;
      default: return lock_fail;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input bit val,
                          input int budget, output int edges);
    int start;
    start = ecnt;
    edges = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge refclk);
      if (sig(which) == val) begin
        edges = ecnt - start;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no response in %0d cycles, required signal %0d = %0b", name, budget, which, val);
  endtask

  task automatic check_outputs(input string name, input bit p, input bit c, input bit r,
                               input bit f, input int rc);
    check({name, "_pll_rst"}, int'(pll_rst), int'(p));
    check({name, "_core_reset"}, int'(core_reset), int'(c));
    check({name, "_ready"}, int'(ready), int'(r));
    check({name, "_lock_fail"}, int'(lock_fail), int'(f));
    check({name, "_relock"}, int'(relock_count), rc);
  endtask

  task automatic random_phase(input int cycles);
    int hold;
    hold = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge refclk);
      if (hold == 0) begin
        locked = ($urandom_range(0, 3) != 0);
        hold   = $urandom_range(1, 30);
      end
      hold--;
      restart = ($urandom_range(0, 63) == 0);
    end
    @(negedge refclk);
    restart = 1'b0;
  endtask

  initial begin
    int d, t0, pulses;
    int rise[5];
    int fall[5];
    int lfr[5];

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge refclk);
    check_outputs("reset", 1'b1, 1'b1, 1'b0, 1'b0, 0);

    // Power-up
    rst_n = 1'b1;
    wait_for("pwr_pll_rst_fall", 0, 1'b0, 10, d);
    check("pwr_pll_rst_width", d, RSTC);
    repeat (6) @(negedge refclk);
    locked = 1'b1;
    wait_for("pwr_core_release", 1, 1'b0, 40, d);
    check("pwr_core_release_delay", d, 3 + ST);
    check("pwr_ready", int'(ready), 1);

    // Lock loss in RUN
    locked = 1'b0;
    wait_for("loss_core_reset", 1, 1'b1, 10, d);
    check("loss_latency", d, 3);
    check_outputs("loss", 1'b1, 1'b1, 1'b0, 1'b0, 1);
    locked = 1'b1;
    wait_for("loss_recover", 2, 1'b1, 60, d);

    // Stability glitch
    locked = 1'b0;
    wait_for("stab_enter_reset", 0, 1'b1, 10, d);
    wait_for("stab_wait_lock", 0, 1'b0, 10, d);
    locked = 1'b1;
    t0 = ecnt;
    repeat (6) @(negedge refclk);
    locked = 1'b0;
    @(negedge refclk);
    locked = 1'b1;
    pulses = 0;
    d = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge refclk);
      if (pll_rst) pulses++;
      if (ready) begin d = ecnt - t0; break; end
    end
    check("stab_run_delay", d, 3 + 5 + 2 + ST);
    check("stab_no_pll_rst", pulses, 0);
    check("stab_relock", int'(relock_count), 2);

    // Timeout retry
    locked = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_for("to_rise", 0, 1'b1, 40, d);
      rise[k] = ecnt;
      lfr[k]  = int'(lock_fail);
      wait_for("to_fall", 0, 1'b0, 10, d);
      fall[k] = ecnt;
    end
    for (int k = 0; k < 5; k++) check("to_pulse_width", fall[k] - rise[k], RSTC);
    for (int k = 0; k < 4; k++) check("to_pulse_period", rise[k+1] - rise[k], RSTC + TO);
    check("to_fail_after_2", lfr[2], 0);
    check("to_fail_after_3", lfr[3], 1);
    check("to_fail_sticky", lfr[4], 1);
    locked = 1'b1;
    wait_for("to_reach_run", 2, 1'b1, 60, d);
    check("to_run_fail_kept", int'(lock_fail), 1);

    // Restart clears lock_fail
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
    check_outputs("restart", 1'b1, 1'b1, 1'b0, 1'b0, 3);
    wait_for("restart_run", 2, 1'b1, 60, d);

    // Restart coincident with RUN lock loss
    locked = 1'b0;
    repeat (2) @(negedge refclk);
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
    check_outputs("restart_loss", 1'b1, 1'b1, 1'b0, 1'b0, 3);
    locked = 1'b1;
    wait_for("restart_loss_run", 2, 1'b1, 60, d);

    // Relock saturation
    for (int n = 0; n < 300; n++) begin
      locked = 1'b0;
      wait_for("sat_drop", 2, 1'b0, 10, d);
      locked = 1'b1;
      wait_for("sat_run", 2, 1'b1, 60, d);
    end
    check("sat_relock", int'(relock_count), 255);

    random_phase(3000);

    // Async reset mid-STABLE
    locked = 1'b1;
    repeat (3) @(negedge refclk);
    restart = 1'b1;
    @(negedge refclk);
    restart = 1'b0;
    repeat (6) @(negedge refclk);
    check("astab_state", int'({pll_rst, core_reset, ready}), 3'b010);
    #2 rst_n = 1'b0;
    #1 check_outputs("async", 1'b1, 1'b1, 1'b0, 1'b0, 0);
    @(negedge refclk);
    rst_n = 1'b1;
    random_phase(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
